mux2a1class_rr: RTL and testbench

Two-input class merger: accepts the two 10-bit per-class word streams produced by the class demultiplexer and recombines them into a single 8-bit data stream with its class and dest side bits. It is the opposite end of the 1-to-2 class split. Each input is buffered in a small FIFO, and a round-robin arbiter feeds a registered output stage with valid/ready backpressure.

---
 rtl/mux2a1class_rr.sv | 184 ++++++++++++++++++
 tb/tb_mux2a1class_rr.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux2a1class_rr.sv
// mux2a1class_rr
// Merges the two per-class word streams of the class demultiplexer back into
// one payload stream with class/dest side bits. Each input is buffered in a
// DEPTH-entry FIFO; a round-robin arbiter feeds a registered output stage with
// valid/ready backpressure.
//
// Ports:
//   clk            rising-edge clock
//   reset_L        synchronous active-low reset
//   inclass0/1     input words {dest, class, data[DATA_WIDTH-1:0]}
//   valid0/1       input word valid
//   ready0/1       FIFO n has room (registered count < DEPTH), 0 during reset
//   dataout_class  merged payload
//   class_out      class bit of the output word
//   dest_out       dest bit of the output word
//   valid_out      output word valid
//   ready_out      downstream accepts the output word
//   err_class      one-cycle pulse on a class mismatch at push
//
// Optional feature: MUX_CLASS_CHECK_EN enables the class check. When it is
// undefined every word is stored as received and err_class is tied to 0.
module mux2a1class_rr #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH+1:0] inclass0,
  input  logic                  valid0,
  output logic                  ready0,
  input  logic [DATA_WIDTH+1:0] inclass1,
  input  logic                  valid1,
  output logic                  ready1,
  output logic [DATA_WIDTH-1:0] dataout_class,
  output logic                  class_out,
  output logic                  dest_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  err_class
);

  localparam int WW = DATA_WIDTH + 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WW-1:0] r_mem0 [DEPTH];
  logic [WW-1:0] r_mem1 [DEPTH];
  logic [AW-1:0] r_wp0, r_rp0, r_wp1, r_rp1;
  logic [CW-1:0] r_cnt0, r_cnt1;
  logic          r_last_grant;

  logic          w_hs0, w_hs1;
  logic          w_keep0, w_keep1;
  logic          w_push0, w_push1;
  logic          w_pop0, w_pop1;
  logic          w_ne0, w_ne1;
  logic          w_load;
  logic          w_grant;
  logic [WW-1:0] w_word;

  assign ready0 = reset_L && (r_cnt0 < CNT_FULL);
  assign ready1 = reset_L && (r_cnt1 < CNT_FULL);

  assign w_hs0 = valid0 && ready0;
  assign w_hs1 = valid1 && ready1;

`ifdef MUX_CLASS_CHECK_EN
  // A mismatching word completes its handshake but is never written.
  assign w_keep0 = (inclass0[DATA_WIDTH] == 1'b0);
  assign w_keep1 = (inclass1[DATA_WIDTH] == 1'b1);
`else
  assign w_keep0 = 1'b1;
  assign w_keep1 = 1'b1;
`endif

  assign w_push0 = w_hs0 && w_keep0;
  assign w_push1 = w_hs1 && w_keep1;

  assign w_ne0  = (r_cnt0 != '0);
  assign w_ne1  = (r_cnt1 != '0);
  assign w_load = !valid_out || ready_out;

  // Arbitration: a lone non-empty FIFO wins; on a tie the one not granted last time wins.
  always_comb begin
    w_grant = 1'b0;
    if (w_ne0 && w_ne1) begin
      w_grant = ~r_last_grant;
    end else if (w_ne1) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  assign w_pop0 = w_load && w_ne0 && !w_grant;
  assign w_pop1 = w_load && w_ne1 && w_grant;
  assign w_word = w_grant ? r_mem1[r_rp1] : r_mem0[r_rp0];

  // FIFO storage writes (payload only, no reset needed).
  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_mem0[r_wp0] <= inclass0;
    end
    if (w_push1) begin
      r_mem1[r_wp1] <= inclass1;
    end
  end

  // FIFO 0 pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_wp0  <= '0;
      r_rp0  <= '0;
      r_cnt0 <= '0;
    end else begin
      if (w_push0) r_wp0 <= r_wp0 + PTR_ONE;
      if (w_pop0)  r_rp0 <= r_rp0 + PTR_ONE;
      case ({w_push0, w_pop0})
        2'b10:   r_cnt0 <= r_cnt0 + CNT_ONE;
        2'b01:   r_cnt0 <= r_cnt0 - CNT_ONE;
        default: r_cnt0 <= r_cnt0;
      endcase
    end
  end

  // FIFO 1 pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_wp1  <= '0;
      r_rp1  <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_push1) r_wp1 <= r_wp1 + PTR_ONE;
      if (w_pop1)  r_rp1 <= r_rp1 + PTR_ONE;
      case ({w_push1, w_pop1})
        2'b10:   r_cnt1 <= r_cnt1 + CNT_ONE;
        2'b01:   r_cnt1 <= r_cnt1 - CNT_ONE;
        default: r_cnt1 <= r_cnt1;
      endcase
    end
  end

  // Output register: loads when empty or being consumed, holds while stalled.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      valid_out     <= 1'b0;
      dataout_class <= '0;
      class_out     <= 1'b0;
      dest_out      <= 1'b0;
      r_last_grant  <= 1'b1;
    end else if (w_load) begin
      if (w_ne0 || w_ne1) begin
        valid_out     <= 1'b1;
        dataout_class <= w_word[DATA_WIDTH-1:0];
        class_out     <= w_word[DATA_WIDTH];
        dest_out      <= w_word[DATA_WIDTH+1];
        r_last_grant  <= w_grant;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef MUX_CLASS_CHECK_EN
  logic r_err;

  // One pulse covers mismatches on either or both inputs in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_hs0 && !w_keep0) || (w_hs1 && !w_keep1);
    end
  end

  assign err_class = r_err;
`else
  assign err_class = 1'b0;
`endif

endmodule

// File: tb/tb_mux2a1class_rr.sv
module tb_mux2a1class_rr;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [9:0] inclass0, inclass1;
  logic       valid0, valid1, ready0, ready1;
  logic [7:0] dataout_class;
  logic       class_out, dest_out, valid_out, ready_out, err_class;

  int n_checks = 0;
  int n_errors = 0;

  mux2a1class_rr #(.DATA_WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .reset_L(reset_L),
    .inclass0(inclass0), .valid0(valid0), .ready0(ready0),
    .inclass1(inclass1), .valid1(valid1), .ready1(ready1),
    .dataout_class(dataout_class), .class_out(class_out), .dest_out(dest_out),
    .valid_out(valid_out), .ready_out(ready_out), .err_class(err_class)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic c, input logic de);
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check({tag, "_data"},  {24'd0, dataout_class}, {24'd0, d});
    check({tag, "_class"}, {31'd0, class_out}, {31'd0, c});
    check({tag, "_dest"},  {31'd0, dest_out}, {31'd0, de});
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    step();
    step();
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0; ready_out = 1'b1;
    inclass0 = 10'h0AA; inclass1 = 10'h155;
    valid0 = 1'b1; valid1 = 1'b1;
    #1;
    // Reset held two edges with valids asserted
    step();
    step();
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_data", {24'd0, dataout_class}, 32'd0);
    check("rst_class", {31'd0, class_out}, 32'd0);
    check("rst_dest", {31'd0, dest_out}, 32'd0);
    check("rst_err", {31'd0, err_class}, 32'd0);
    check("rst_ready0", {31'd0, ready0}, 32'd0);
    check("rst_ready1", {31'd0, ready1}, 32'd0);
    reset_L = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
    #1;
    check("rel_ready0", {31'd0, ready0}, 32'd1);
    check("rel_ready1", {31'd0, ready1}, 32'd1);
    step();
    check("rel_nothing_stored", {31'd0, valid_out}, 32'd0);

    // Single word
    inclass0 = 10'h0A5; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    check("single_lat1", {31'd0, valid_out}, 32'd0);
    step();
    check_out("single", 8'hA5, 1'b0, 1'b0);
    step();
    check("single_after", {31'd0, valid_out}, 32'd0);

    // Tie and round robin from a fresh reset
    do_reset();
    inclass0 = 10'h011; inclass1 = 10'h111; valid0 = 1'b1; valid1 = 1'b1;
    step();
    inclass0 = 10'h012; inclass1 = 10'h112;
    step();
    valid0 = 1'b0; valid1 = 1'b0;
    check_out("rr0", 8'h11, 1'b0, 1'b0);
    step();
    check_out("rr1", 8'h11, 1'b1, 1'b0);
    step();
    check_out("rr2", 8'h12, 1'b0, 1'b0);
    step();
    check_out("rr3", 8'h12, 1'b1, 1'b0);
    step();
    check("rr_end", {31'd0, valid_out}, 32'd0);

    // Backpressure and full FIFO 0
    do_reset();
    ready_out = 1'b0;
    inclass0 = 10'h021; valid0 = 1'b1;
    step();
    inclass0 = 10'h022;
    step();
    check_out("bp_first", 8'h21, 1'b0, 1'b0);
    check("bp_ready0_cnt1", {31'd0, ready0}, 32'd1);
    inclass0 = 10'h023;
    step();
    valid0 = 1'b0;
    check("bp_full_ready0", {31'd0, ready0}, 32'd0);
    step();
    check_out("bp_hold", 8'h21, 1'b0, 1'b0);
    check("bp_still_full", {31'd0, ready0}, 32'd0);
    ready_out = 1'b1;
    step();
    check_out("bp_w2", 8'h22, 1'b0, 1'b0);
    check("bp_ready0_back", {31'd0, ready0}, 32'd1);
    step();
    check_out("bp_w3", 8'h23, 1'b0, 1'b0);
    step();
    check("bp_end", {31'd0, valid_out}, 32'd0);

    // Simultaneous push/pop at count 1 on input 1
    do_reset();
    inclass1 = 10'h131; valid1 = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      inclass1 = 10'h132 + 10'(i);
      step();
      check_out("pp", 8'h31 + 8'(i), 1'b1, 1'b0);
      check("pp_ready1", {31'd0, ready1}, 32'd1);
    end
    valid1 = 1'b0;
    step();
    check_out("pp_last", 8'h35, 1'b1, 1'b0);
    step();
    check("pp_end", {31'd0, valid_out}, 32'd0);

    // Class-mismatched word on input 0
    do_reset();
    #1;
    check("cm_ready0", {31'd0, ready0}, 32'd1);
    inclass0 = 10'h1FF; valid0 = 1'b1;
    step();
    valid0 = 1'b0;
`ifdef MUX_CLASS_CHECK_EN
    check("cm_err_pulse", {31'd0, err_class}, 32'd1);
    step();
    check("cm_err_clear", {31'd0, err_class}, 32'd0);
    check("cm_dropped", {31'd0, valid_out}, 32'd0);
    step();
    check("cm_dropped2", {31'd0, valid_out}, 32'd0);
`else
    check("cm_err0_a", {31'd0, err_class}, 32'd0);
    step();
    check_out("cm_fwd", 8'hFF, 1'b1, 1'b0);
    check("cm_err0_b", {31'd0, err_class}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
